// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: arbitrates, latches one operation,
// runs it through the external ALU for one cycle and holds the result until taken.
module alu_arbiter #(
    parameter int unsigned FAIR = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_data,
    output logic        rsp0_neg,
    output logic        rsp0_of,
    output logic        rsp0_zero,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_data,
    output logic        rsp1_neg,
    output logic        rsp1_of,
    output logic        rsp1_zero,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_neg,
    input  logic        alu_of,
    input  logic        alu_zero,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last_grant;
    logic        r_grant;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_res;
    logic        r_neg;
    logic        r_of;
    logic        r_zero;
    logic        w_win;
    logic        w_accept;

    // w_win is the index of the winning requester; only meaningful when one is valid
    always_comb begin
        w_win = 1'b0;
        if (FAIR != 0) begin
            if (req0_valid && req1_valid) w_win = ~r_last_grant;
            else                          w_win = req1_valid;
        end else begin
            w_win = ~req0_valid;
        end
    end

    assign w_accept = (r_state == IDLE) && !RST && (req0_valid || req1_valid);

    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        alu_op     = '0;
        alu_a      = '0;
        alu_b      = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next     = EXEC;
                    req0_ready = ~w_win;
                    req1_ready = w_win;
                end
            end
            EXEC: begin
                alu_op = r_op;
                alu_a  = r_a;
                alu_b  = r_b;
                w_next = RESP;
            end
            RESP: begin
                if (!r_grant) begin
                    rsp0_valid = 1'b1;
                    if (rsp0_ready) w_next = IDLE;
                end else begin
                    rsp1_valid = 1'b1;
                    if (rsp1_ready) w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_neg        <= 1'b0;
            r_of         <= 1'b0;
            r_zero       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant      <= w_win;
                r_last_grant <= w_win;
                r_op         <= w_win ? req1_op : req0_op;
                r_a          <= w_win ? req1_a  : req0_a;
                r_b          <= w_win ? req1_b  : req0_b;
            end
            if (r_state == EXEC) begin
                r_res  <= alu_out;
                r_neg  <= alu_neg;
                r_of   <= alu_of;
                r_zero <= alu_zero;
            end
        end
    end

    assign rsp0_data = r_res;
    assign rsp0_neg  = r_neg;
    assign rsp0_of   = r_of;
    assign rsp0_zero = r_zero;
    assign rsp1_data = r_res;
    assign rsp1_neg  = r_neg;
    assign rsp1_of   = r_of;
    assign rsp1_zero = r_zero;
    assign busy      = (r_state != IDLE);
    assign grant     = r_grant;

endmodule
